// File: rtl/fmmu_multi_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fmmu_multi_map                                                   |
// | Purpose  : Maps a logical datagram window onto N_CH FMMU channels, emitting |
// |            one physical segment per overlapping channel in channel order.   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fmmu_multi_map #(
  parameter int N_CH    = 4,
  parameter int LADDR_W = 32,
  parameter int PADDR_W = 16,
  parameter int LEN_W   = 16,
  localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               RST,
  // channel configuration
  input  logic               cfg_we,
  input  logic [c_CH_W-1:0]  cfg_ch,
  input  logic               cfg_en,
  input  logic [LADDR_W-1:0] cfg_lstart,
  input  logic [LEN_W-1:0]   cfg_llen,
  input  logic [PADDR_W-1:0] cfg_pstart,
  output logic               cfg_ready,
  // datagram request
  input  logic [LADDR_W-1:0] sub_address,
  input  logic [LEN_W-1:0]   sub_len,
  input  logic               subdv,
  output logic               req_ready,
  // segment stream
  output logic [PADDR_W-1:0] bus_address,
  output logic [LEN_W-1:0]   fmmu_map_address_len,
  output logic [LEN_W-1:0]   seg_offset,
  output logic [c_CH_W-1:0]  seg_ch,
  output logic               seg_valid,
  input  logic               seg_ready,
  // completion
  output logic               done,
  output logic               miss
);

  localparam int c_SUM_W = LADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // channel configuration registers
  logic               r_cfg_en     [N_CH];
  logic [LADDR_W-1:0] r_cfg_lstart [N_CH];
  logic [LEN_W-1:0]   r_cfg_llen   [N_CH];
  logic [PADDR_W-1:0] r_cfg_pstart [N_CH];

  // captured request and scan bookkeeping
  logic [LADDR_W-1:0] r_req_addr;
  logic [LEN_W-1:0]   r_req_len;
  logic [c_CH_W-1:0]  r_ch_idx;
  logic               r_hit_any;

  // registered segment outputs
  logic [PADDR_W-1:0] r_bus;
  logic [LEN_W-1:0]   r_seg_len;
  logic [LEN_W-1:0]   r_seg_off;
  logic [c_CH_W-1:0]  r_seg_ch;
  logic               r_done;
  logic               r_miss;

  logic               w_idle;
  logic               w_req_acc;
  logic               w_cfg_wr;
  logic               w_last;

  // selected channel and overlap arithmetic
  logic               w_sel_en;
  logic [LADDR_W-1:0] w_sel_lstart;
  logic [LEN_W-1:0]   w_sel_llen;
  logic [PADDR_W-1:0] w_sel_pstart;
  logic [c_SUM_W-1:0] w_a;
  logic [c_SUM_W-1:0] w_a_end;
  logic [c_SUM_W-1:0] w_s;
  logic [c_SUM_W-1:0] w_s_end;
  logic [c_SUM_W-1:0] w_lo;
  logic [c_SUM_W-1:0] w_hi;
  logic               w_hit;
  logic [PADDR_W-1:0] w_bus;
  logic [LEN_W-1:0]   w_seg_len;
  logic [LEN_W-1:0]   w_seg_off;

  assign w_idle    = (r_state == S_IDLE);
  assign w_req_acc = w_idle && subdv;
  assign w_cfg_wr  = w_idle && cfg_we;
  assign w_last    = (r_ch_idx == c_CH_W'(N_CH - 1));

  // Config writes share the IDLE window with requests, so a write landing on the
  // accept edge is already visible when the first channel is scanned.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cfg_en[i]     <= 1'b0;
        r_cfg_lstart[i] <= '0;
        r_cfg_llen[i]   <= '0;
        r_cfg_pstart[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      for (int i = 0; i < N_CH; i++) begin
        if (int'(cfg_ch) == i) begin
          r_cfg_en[i]     <= cfg_en;
          r_cfg_lstart[i] <= cfg_lstart;
          r_cfg_llen[i]   <= cfg_llen;
          r_cfg_pstart[i] <= cfg_pstart;
        end
      end
    end
  end

  assign w_sel_en     = r_cfg_en[r_ch_idx];
  assign w_sel_lstart = r_cfg_lstart[r_ch_idx];
  assign w_sel_llen   = r_cfg_llen[r_ch_idx];
  assign w_sel_pstart = r_cfg_pstart[r_ch_idx];

  // One extra bit keeps window ends from wrapping past the top of logical space.
  always_comb begin
    w_a       = {1'b0, r_req_addr};
    w_a_end   = w_a + c_SUM_W'(r_req_len);
    w_s       = {1'b0, w_sel_lstart};
    w_s_end   = w_s + c_SUM_W'(w_sel_llen);
    w_lo      = (w_a > w_s) ? w_a : w_s;
    w_hi      = (w_a_end < w_s_end) ? w_a_end : w_s_end;
    w_hit     = w_sel_en && (r_req_len != '0) && (w_sel_llen != '0) && (w_lo < w_hi);
    w_bus     = w_sel_pstart + PADDR_W'(w_lo - w_s);
    w_seg_len = LEN_W'(w_hi - w_lo);
    w_seg_off = LEN_W'(w_lo - w_a);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_acc) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          w_state_nxt = S_EMIT;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_EMIT: begin
        if (seg_ready) begin
          w_state_nxt = w_last ? S_DONE : S_SCAN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: the channel index only advances after a channel is fully
  // resolved (miss in SCAN, or handshake in EMIT).
  always_ff @(posedge clk) begin
    if (RST) begin
      r_req_addr <= '0;
      r_req_len  <= '0;
      r_ch_idx   <= '0;
      r_hit_any  <= 1'b0;
      r_bus      <= '0;
      r_seg_len  <= '0;
      r_seg_off  <= '0;
      r_seg_ch   <= '0;
      r_done     <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      r_miss <= (r_state == S_DONE) && !r_hit_any;
      case (r_state)
        S_IDLE: begin
          if (w_req_acc) begin
            r_req_addr <= sub_address;
            r_req_len  <= sub_len;
            r_ch_idx   <= '0;
            r_hit_any  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_bus     <= w_bus;
            r_seg_len <= w_seg_len;
            r_seg_off <= w_seg_off;
            r_seg_ch  <= r_ch_idx;
            r_hit_any <= 1'b1;
          end else if (!w_last) begin
            r_ch_idx <= r_ch_idx + c_CH_W'(1);
          end
        end
        S_EMIT: begin
          if (seg_ready && !w_last) begin
            r_ch_idx <= r_ch_idx + c_CH_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready            = w_idle;
  assign cfg_ready            = w_idle;
  assign seg_valid            = (r_state == S_EMIT);
  assign bus_address          = r_bus;
  assign fmmu_map_address_len = r_seg_len;
  assign seg_offset           = r_seg_off;
  assign seg_ch               = r_seg_ch;
  assign done                 = r_done;
  assign miss                 = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_fmmu_multi_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fmmu_multi_map                                                |
// | Purpose  : Randomized self-checking bench with an interval-overlap model.   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fmmu_multi_map;

  localparam int N_CH    = 4;
  localparam int LADDR_W = 32;
  localparam int PADDR_W = 16;
  localparam int LEN_W   = 16;
  localparam int CH_W    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic               cfg_en;
  logic [LADDR_W-1:0] cfg_lstart;
  logic [LEN_W-1:0]   cfg_llen;
  logic [PADDR_W-1:0] cfg_pstart;
  logic               cfg_ready;
  logic [LADDR_W-1:0] sub_address;
  logic [LEN_W-1:0]   sub_len;
  logic               subdv;
  logic               req_ready;
  logic [PADDR_W-1:0] bus_address;
  logic [LEN_W-1:0]   fmmu_map_address_len;
  logic [LEN_W-1:0]   seg_offset;
  logic [CH_W-1:0]    seg_ch;
  logic               seg_valid;
  logic               seg_ready;
  logic               done;
  logic               miss;

  always #5 clk = ~clk;

  fmmu_multi_map #(
    .N_CH    (N_CH),
    .LADDR_W (LADDR_W),
    .PADDR_W (PADDR_W),
    .LEN_W   (LEN_W)
  ) u_dut (
    .clk                  (clk),
    .RST                  (rst),
    .cfg_we               (cfg_we),
    .cfg_ch               (cfg_ch),
    .cfg_en               (cfg_en),
    .cfg_lstart           (cfg_lstart),
    .cfg_llen             (cfg_llen),
    .cfg_pstart           (cfg_pstart),
    .cfg_ready            (cfg_ready),
    .sub_address          (sub_address),
    .sub_len              (sub_len),
    .subdv                (subdv),
    .req_ready            (req_ready),
    .bus_address          (bus_address),
    .fmmu_map_address_len (fmmu_map_address_len),
    .seg_offset           (seg_offset),
    .seg_ch               (seg_ch),
    .seg_valid            (seg_valid),
    .seg_ready            (seg_ready),
    .done                 (done),
    .miss                 (miss)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: channel table plus expected segment list per request.
  bit              m_en  [N_CH];
  longint unsigned m_ls  [N_CH];
  longint unsigned m_len [N_CH];
  longint unsigned m_ps  [N_CH];
  logic [63:0]     exp_q [$];

  function automatic logic [63:0] pack_seg(input logic [15:0] bus, input logic [15:0] len,
                                           input logic [15:0] off, input logic [15:0] ch);
    return {bus, len, off, ch};
  endfunction

  function automatic logic [63:0] dut_seg();
    return {bus_address, fmmu_map_address_len, seg_offset, 14'd0, seg_ch};
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_en[c] = 1'b0; m_ls[c] = 0; m_len[c] = 0; m_ps[c] = 0;
    end
  endfunction

  function automatic void model_set(input int ch, input bit en, input longint unsigned ls,
                                    input longint unsigned len, input longint unsigned ps);
    m_en[ch] = en; m_ls[ch] = ls; m_len[ch] = len; m_ps[ch] = ps;
  endfunction

  function automatic void model_expect(input longint unsigned a, input longint unsigned l);
    exp_q.delete();
    for (int c = 0; c < N_CH; c++) begin
      longint unsigned s = m_ls[c];
      longint unsigned m = m_len[c];
      longint unsigned lo, hi;
      if (!m_en[c] || l == 0 || m == 0) continue;
      lo = (a > s) ? a : s;
      hi = ((a + l) < (s + m)) ? (a + l) : (s + m);
      if (lo < hi)
        exp_q.push_back(pack_seg(16'((m_ps[c] + (lo - s)) % 65536), 16'(hi - lo),
                                 16'(lo - a), 16'(c)));
    end
  endfunction

  task automatic drive_cfg(input int ch, input bit en, input longint unsigned ls,
                           input longint unsigned len, input longint unsigned ps);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_en = en;
    cfg_lstart = 32'(ls); cfg_llen = 16'(len); cfg_pstart = 16'(ps);
  endtask

  task automatic cfg_write(input int ch, input bit en, input longint unsigned ls,
                           input longint unsigned len, input longint unsigned ps);
    check_eq("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    drive_cfg(ch, en, ls, len, ps);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_set(ch, en, ls, len, ps);
  endtask

  // Issue one request and follow it to done. Each segment is stalled at least
  // min_stall cycles, then released with probability rdy_pct percent per cycle.
  task automatic run_req(input longint unsigned a, input longint unsigned l,
                         input int rdy_pct, input int min_stall);
    bit          stall;
    bit          got_done;
    logic [63:0] held;
    int          n_exp;
    int          n_seen;
    int          stall_cnt;
    model_expect(a, l);
    n_exp = exp_q.size();
    n_seen = 0; stall = 0; got_done = 0; stall_cnt = 0; held = '0;
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    sub_address = 32'(a); sub_len = 16'(l); subdv = 1'b1; seg_ready = 1'b0;
    @(posedge clk); #1;
    subdv = 1'b0; cfg_we = 1'b0;
    sub_address = $urandom; sub_len = 16'($urandom);
    for (int k = 0; k < 400 && !got_done; k++) begin
      if (stall) begin
        check_eq("stall_valid", 64'(seg_valid), 64'd1);
        check_eq("stall_hold", dut_seg(), held);
      end
      subdv = 1'b0; cfg_we = 1'b0; stall = 0;
      if (done) begin
        got_done = 1;
        check_eq("miss", 64'(miss), 64'(n_exp == 0));
        check_eq("segs_left", 64'(exp_q.size()), 64'd0);
        if (n_exp == 0) check_eq("miss_latency", 64'(k), 64'(N_CH + 1));
        seg_ready = 1'b0;
      end else if (seg_valid) begin
        check_eq("busy_ready", {62'd0, req_ready, cfg_ready}, 64'd0);
        if (stall_cnt >= min_stall && int'($urandom_range(99)) < rdy_pct) begin
          seg_ready = 1'b1; stall_cnt = 0;
          if (exp_q.size() == 0) check_eq("seg_count", 64'(n_seen + 1), 64'(n_exp));
          else check_eq("seg", dut_seg(), exp_q.pop_front());
          n_seen++;
        end else begin
          seg_ready = 1'b0; stall = 1; stall_cnt++; held = dut_seg();
          // stray traffic while busy must be dropped
          subdv = 1'b1; sub_address = $urandom; sub_len = 16'($urandom);
          drive_cfg(int'($urandom_range(N_CH - 1)), 1'b1, $urandom, $urandom_range(255), $urandom);
        end
      end else begin
        seg_ready = 1'($urandom);
      end
      if (!got_done) begin
        @(posedge clk); #1;
      end
    end
    seg_ready = 1'b0; subdv = 1'b0; cfg_we = 1'b0;
    check_eq("done_timeout", 64'(got_done), 64'd1);
    if (!got_done) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      model_clear();
    end
  endtask

  function automatic longint unsigned rand_addr(input bit top);
    longint unsigned base = top ? 64'hFFFF_FFC0 : 64'h1414_1400;
    return base + longint'($urandom_range(63));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_lstart = '0;
    cfg_llen = '0; cfg_pstart = '0; sub_address = '0; sub_len = '0;
    subdv = 1'b0; seg_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_seg_valid", 64'(seg_valid), 64'd0);
    check_eq("rst_done_miss", {62'd0, done, miss}, 64'd0);
    check_eq("rst_seg_regs", dut_seg(), 64'd0);
    check_eq("rst_ready", {62'd0, req_ready, cfg_ready}, 64'd3);
    run_req(64'h1414_1413, 2, 100, 0);

    // single partial hit
    cfg_write(0, 1, 64'h1414_1414, 2, 64'h1001);
    run_req(64'h1414_1413, 2, 100, 0);
    // clean miss with latency check
    run_req(64'h1000_0000, 1, 100, 0);
    // two channels, then the same with forced stalls
    cfg_write(1, 1, 64'h1414_1416, 4, 64'h2000);
    run_req(64'h1414_1412, 8, 100, 0);
    run_req(64'h1414_1412, 8, 100, 3);

    // top-of-space window must not wrap; zero length never hits
    cfg_write(0, 0, 0, 0, 0);
    cfg_write(1, 0, 0, 0, 0);
    cfg_write(2, 1, 64'hFFFF_FFFE, 4, 64'h3000);
    run_req(64'h0000_0000, 2, 100, 0);
    run_req(64'hFFFF_FFFE, 0, 100, 0);
    run_req(64'hFFFF_FFFF, 4, 100, 0);

    // config written on the accept edge is used by the scan
    drive_cfg(3, 1, 64'h500, 16, 64'h4000);
    model_set(3, 1, 64'h500, 16, 64'h4000);
    run_req(64'h508, 4, 70, 1);

    // reset in the middle of a segment handshake
    cfg_write(0, 1, 64'h100, 8, 64'h10);
    sub_address = 32'h100; sub_len = 16'd4; subdv = 1'b1; seg_ready = 1'b0;
    @(posedge clk); #1;
    subdv = 1'b0;
    for (int i = 0; i < 10 && !seg_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_reach_emit", 64'(seg_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check_eq("midrst_seg_valid", 64'(seg_valid), 64'd0);
    check_eq("midrst_ready", {62'd0, req_ready, cfg_ready}, 64'd3);
    check_eq("midrst_seg_regs", dut_seg(), 64'd0);
    run_req(64'h100, 4, 100, 0);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      bit top = 1'($urandom);
      int nw = int'($urandom_range(2));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(N_CH - 1)), ($urandom_range(9) < 8), rand_addr(top),
                  $urandom_range(23), $urandom_range(65535));
      if ($urandom_range(4) == 0) begin
        int ch = int'($urandom_range(N_CH - 1));
        longint unsigned ls = rand_addr(top);
        longint unsigned ln = $urandom_range(23);
        longint unsigned ps = $urandom_range(65535);
        drive_cfg(ch, 1'b1, ls, ln, ps);
        model_set(ch, 1'b1, ls, ln, ps);
      end
      run_req(rand_addr(top), $urandom_range(31), 60, int'($urandom_range(2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
